uart_cmd_assembler: RTL
=======================

UART_CMD_ASSEMBLER -- requirements
Module: uart_cmd_assembler

Interface
REQ-001 Parameter: TIMEOUT_CLKS, 16'd50000, clocks allowed between high and low command bytes.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 rx_rdy  in  1  UART receiver byte-available level; held until knocked down.
REQ-005 rx_data  in  8  received byte; valid while rx_rdy high.
REQ-006 clr_rx_rdy  out  1  one-cycle knock-down pulse to UART receiver.
REQ-007 cmd  out  16  assembled command: {high byte, low byte}.
REQ-008 cmd_rdy  out  1  level; new command valid on cmd.
REQ-009 clr_cmd_rdy  in  1  consumer acknowledge; clears cmd_rdy.
REQ-010 resp  in  8  response byte from command processor.
REQ-011 send_resp  in  1  one-cycle request to transmit resp.
REQ-012 trmt  out  1  one-cycle start pulse to UART transmitter.
REQ-013 tx_data  out  8  byte to transmit; stable from trmt until tx_done.
REQ-014 tx_done  in  1  UART transmitter completion pulse.
REQ-015 frm_err  out  1  one-cycle pulse on inter-byte timeout.

Function
REQ-016 Receive FSM SHALL have states IDLE and WAIT_LO.
REQ-017 A byte SHALL be accepted only in a cycle with rx_rdy=1 and clr_rx_rdy=0; clr_rx_rdy SHALL pulse exactly once, in the cycle after each acceptance.
REQ-018 IDLE, accept: store rx_data as high byte, clear cmd_rdy, go to WAIT_LO.
REQ-019 WAIT_LO, accept: cmd <= {high byte, rx_data} and cmd_rdy=1, both visible the cycle after acceptance; go to IDLE.
REQ-020 cmd SHALL hold its value until the next completed command; cmd SHALL NOT change during WAIT_LO.
REQ-021 cmd_rdy SHALL clear the cycle after clr_cmd_rdy=1; if command completion and clr_cmd_rdy coincide, cmd_rdy SHALL remain 1.
REQ-022 Transmit path SHALL have a busy flag and a one-entry pending buffer (pend_vld, pend_data).
REQ-023 send_resp with not busy: trmt=1 and tx_data=resp next cycle; busy set.
REQ-024 send_resp while busy: resp stored in pending buffer; an already-full buffer is overwritten by the newer byte.
REQ-025 tx_done with pend_vld: trmt=1, tx_data=pend_data next cycle, pend_vld cleared, busy stays 1; tx_done without pend_vld: busy cleared.
REQ-026 tx_done and send_resp in the same cycle, buffer empty: resp transmitted next cycle directly (no buffering).
REQ-027 trmt SHALL never be high for two consecutive cycles.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, cmd=16'h0000, cmd_rdy=0, clr_rx_rdy=0, trmt=0, tx_data=8'h00, frm_err=0, busy=0, pend_vld=0, timeout counter=0.
REQ-029 A partially received command (high byte only) SHALL be discarded by reset.

Configuration
REQ-030 Macro CMD_TIMEOUT_EN defined: 16-bit counter clears on entry to WAIT_LO and increments each WAIT_LO cycle; when it reaches TIMEOUT_CLKS-1 without a low byte, high byte discarded, FSM returns to IDLE, frm_err pulses one cycle.
REQ-031 A low byte accepted in the same cycle the counter reaches TIMEOUT_CLKS-1 SHALL complete the command; frm_err SHALL NOT pulse.
REQ-032 Macro CMD_TIMEOUT_EN undefined: no counter, WAIT_LO held indefinitely, frm_err tied 0.

Verification
REQ-033 Bytes 8'h47 then 8'hF3 -> cmd=16'h47F3, cmd_rdy=1 one cycle after second acceptance, two clr_rx_rdy pulses total.
REQ-034 CMD_TIMEOUT_EN, TIMEOUT_CLKS=100: byte 8'h47, idle 100 clocks -> one frm_err pulse, cmd unchanged; then 8'h29, 8'h00 -> cmd=16'h2900.
REQ-035 rx_rdy held high 3 cycles for one byte 8'h12 -> exactly one acceptance, FSM in WAIT_LO.
REQ-036 send_resp 8'hA5 when idle, then 8'h5A and 8'h3C while busy -> trmt with A5; after tx_done, trmt with 3C; 5A never sent.
REQ-037 rst_n low after high byte 8'h47, then bytes 8'h23, 8'h80 -> cmd=16'h2380.
REQ-038 clr_cmd_rdy asserted in the cycle the low byte of 16'h4010 is accepted -> cmd_rdy=1, cmd=16'h4010.

Source files
------------

// File: rtl/uart_cmd_assembler_if.sv
// uart_cmd_assembler_if: receive-byte, command, response and transmit signals
// of the UART command assembler. The slave modport is the assembler's view and
// the master modport is the surrounding UART/command-processor view.
interface uart_cmd_assembler_if;
   logic        rx_rdy;
   logic [7:0]  rx_data;
   logic        clr_rx_rdy;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic [7:0]  resp;
   logic        send_resp;
   logic        trmt;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic        frm_err;

   modport master (
      output rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
      input  clr_rx_rdy, cmd, cmd_rdy, trmt, tx_data, frm_err
   );

   modport slave (
      input  rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
      output clr_rx_rdy, cmd, cmd_rdy, trmt, tx_data, frm_err
   );
endinterface

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler: builds 16-bit commands from pairs of UART bytes (high
// byte first) and queues response bytes to the UART transmitter through a
// busy flag plus a one-entry overwrite buffer.
// Optional feature: define CMD_TIMEOUT_EN to drop a lone high byte when no low
// byte follows within TIMEOUT_CLKS clocks (frm_err pulses); otherwise the
// assembler waits for the low byte indefinitely and frm_err stays 0.
module uart_cmd_assembler #(
   parameter logic [15:0] TIMEOUT_CLKS = 16'd50000
) (
   input logic                 clk,
   input logic                 rst_n,
   uart_cmd_assembler_if.slave bus
);

   typedef enum logic {IDLE, WAIT_LO} state_t;

   state_t     state;
   state_t     state_nxt;
   logic       armed;
   logic       accept;
   logic       hi_take;
   logic       lo_take;
   logic       timeout;
   logic [7:0] hi_byte;

   logic       busy;
   logic       pend_vld;
   logic [7:0] pend_data;
   logic       done;
   logic       free;

   // A level-held rx_rdy must drop before another byte is taken, so a byte the
   // receiver has not yet knocked down is never accepted twice.
   assign accept = bus.rx_rdy & ~bus.clr_rx_rdy & armed;

`ifdef CMD_TIMEOUT_EN
   logic [15:0] cnt;

   assign timeout = (state == WAIT_LO) && !accept && (cnt == TIMEOUT_CLKS - 16'd1);

   // Inter-byte counter: held at zero in IDLE, counts every WAIT_LO cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (state == IDLE)
         cnt <= '0;
      else
         cnt <= cnt + 16'd1;
   end

   // One-cycle framing error when a high byte is abandoned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bus.frm_err <= 1'b0;
      else
         bus.frm_err <= timeout;
   end
`else
   logic unused_timeout_clks;

   assign unused_timeout_clks = ^TIMEOUT_CLKS;
   assign timeout             = 1'b0;
   assign bus.frm_err         = 1'b0;
`endif

   // Receive FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Receive FSM next state and byte-role decode.
   always_comb begin
      state_nxt = state;
      hi_take   = 1'b0;
      lo_take   = 1'b0;
      case (state)
         IDLE: begin
            hi_take = accept;
            if (accept)
               state_nxt = WAIT_LO;
         end
         WAIT_LO: begin
            lo_take = accept;
            if (accept || timeout)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Receive datapath: knock-down pulse, high-byte hold, command and ready flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.clr_rx_rdy <= 1'b0;
         armed          <= 1'b1;
         hi_byte        <= '0;
         bus.cmd        <= '0;
         bus.cmd_rdy    <= 1'b0;
      end else begin
         bus.clr_rx_rdy <= accept;
         if (accept)
            armed <= 1'b0;
         else if (!bus.rx_rdy)
            armed <= 1'b1;
         if (hi_take)
            hi_byte <= bus.rx_data;
         // completion wins over a coincident acknowledge
         if (lo_take) begin
            bus.cmd     <= {hi_byte, bus.rx_data};
            bus.cmd_rdy <= 1'b1;
         end else if (hi_take || bus.clr_cmd_rdy) begin
            bus.cmd_rdy <= 1'b0;
         end
      end
   end

   // tx_done is ignored while trmt is high so starts can never be back to back.
   assign done = bus.tx_done & busy & ~bus.trmt;
   assign free = ~busy | (done & ~pend_vld);

   // Transmit path: direct start when free, else park the newest byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.trmt    <= 1'b0;
         bus.tx_data <= '0;
         busy        <= 1'b0;
         pend_vld    <= 1'b0;
         pend_data   <= '0;
      end else begin
         bus.trmt <= 1'b0;
         if (done && pend_vld) begin
            bus.trmt    <= 1'b1;
            bus.tx_data <= pend_data;
            pend_vld    <= 1'b0;
         end else if (bus.send_resp && free) begin
            bus.trmt    <= 1'b1;
            bus.tx_data <= bus.resp;
            busy        <= 1'b1;
         end else if (done) begin
            busy <= 1'b0;
         end
         if (bus.send_resp && !free) begin
            pend_vld  <= 1'b1;
            pend_data <= bus.resp;
         end
      end
   end

endmodule
